rx_prbs_checker: RTL and testbench
==================================

RX_PRBS_CHECKER -- requirements
Module: rx_prbs_checker

Interface
REQ-001 Parameter SIG_WIDTH, default FILTER_OUT_WIDTH, width of received filter-output sample.
REQ-002 Parameter CNT_WIDTH, default 32, width of bit and error counters.
REQ-003 Parameter LOCK_COUNT, default 32, consecutive error-free bits needed to declare lock.
REQ-004 Parameter WINDOW, default 64, bits per loss-of-lock evaluation window.
REQ-005 Parameter UNLOCK_ERRS, default 8, errors within one window that force loss of lock.
REQ-006 clk  input  1  system clock (clk_sys domain); all logic on its rising edge.
REQ-007 rst  input  1  synchronous active-low reset; asserted when 0, sampled on rising edge of clk.
REQ-008 cke  input  1  sample strobe (RX rising-edge clock enable); one received bit per cycle with cke=1.
REQ-009 sig  input  SIG_WIDTH  signed two's-complement channel output (FILTER_OUT_FORMAT).
REQ-010 clear  input  1  synchronous counter clear; does not affect lock state.
REQ-011 locked  output  1  checker aligned to PRBS7 stream.
REQ-012 err  output  1  one-cycle pulse: last compared bit mismatched while in VERIFY or LOCKED.
REQ-013 bit_cnt  output  CNT_WIDTH  bits compared while LOCKED.
REQ-014 err_cnt  output  CNT_WIDTH  errors detected while LOCKED.

Function
REQ-015 Slicer: received bit = 1 when sig >= 0, 0 when sig < 0 (inverted MSB); only evaluated on cke=1.
REQ-016 Cycles with cke=0 shall change no state, counter or LFSR; err shall be 0 on them.
REQ-017 Reference generator: 7-bit LFSR s[6:0], PRBS7 x^7+x^6+1; expected bit e = s[6]^s[5]; update s <= {s[5:0], next}.
REQ-018 FSM states SEED, VERIFY, LOCKED; reset state SEED.
REQ-019 SEED: each cke shifts received bit into s (next = received); after 7 bits, go to VERIFY if s != 0, else restart SEED count with s retained (all-zero seed never accepted).
REQ-020 VERIFY: each cke compares received bit to e, shifts e (not received bit) into s; mismatch -> err=1, return to SEED with seed bit count 0; LOCK_COUNT consecutive matches -> LOCKED.
REQ-021 LOCKED: each cke compares and shifts as in VERIFY; bit_cnt +1; on mismatch err=1 and err_cnt +1.
REQ-022 LOCKED window: window bit counter counts cke bits 1..WINDOW then restarts; window error counter zeroed at each window start; when it reaches UNLOCK_ERRS -> SEED on that same update, locked falls.
REQ-023 locked = 1 exactly while state is LOCKED; all outputs registered; err, locked, counters reflect a cke bit in the cycle after that bit is sampled (latency 1).
REQ-024 bit_cnt and err_cnt saturate at all-ones; no wrap.
REQ-025 clear=1 sets bit_cnt and err_cnt to 0 next cycle; clear wins over simultaneous increment.
REQ-026 On loss of lock, bit_cnt and err_cnt hold their values; counting resumes on next LOCKED.
REQ-027 Window counters reset to 0 on every entry to LOCKED.

Reset
REQ-028 rst=0 on a rising edge: state SEED, s=0, seed/verify/window counters 0, locked=0, err=0, bit_cnt=0, err_cnt=0.
REQ-029 Reset mid-operation (any state) takes effect on that edge and overrides cke and clear.

Verification
REQ-030 Reset, then clean PRBS7 (sig=+1000/-1000) with cke every cycle -> locked=1 one cycle after bit 7+32=39; err never 1; bit_cnt increments by 1 per bit thereafter.
REQ-031 Locked stream, one inverted bit -> single err pulse, err_cnt=1, locked stays 1.
REQ-032 Locked stream, 8 bits inverted within one 64-bit window -> locked=0 one cycle after 8th error; counters hold; relock after 39 clean bits.
REQ-033 All-zero input (sig=-1000) for 200 bits -> locked stays 0, err stays 0.
REQ-034 cke asserted every 3rd cycle with clean PRBS7 -> lock after 39 strobed bits; counters unchanged on cke=0 cycles.
REQ-035 Force err_cnt to all-ones near saturation, inject errors -> err_cnt holds all-ones; clear with simultaneous error -> err_cnt=0.

Source files
------------

// File: rtl/rx_prbs_checker.sv
// rtl/rx_prbs_checker.sv - PRBS7 receive checker with self-seeding, lock detection and error counting
module rx_prbs_checker #(
    parameter int SIG_WIDTH   = 16,
    parameter int CNT_WIDTH   = 32,
    parameter int LOCK_COUNT  = 32,
    parameter int WINDOW      = 64,
    parameter int UNLOCK_ERRS = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cke,
    input  logic signed [SIG_WIDTH-1:0] sig,
    input  logic                        clear,
    output logic                        locked,
    output logic                        err,
    output logic        [CNT_WIDTH-1:0] bit_cnt,
    output logic        [CNT_WIDTH-1:0] err_cnt
);

    localparam int VW = $clog2(LOCK_COUNT + 1);
    localparam int WW = $clog2(WINDOW + 1);
    localparam int EW = $clog2(UNLOCK_ERRS + 1);
    localparam logic signed [SIG_WIDTH-1:0] SIG_ZERO = '0;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_SEED,
        ST_VERIFY,
        ST_LOCKED
    } state_t;

    state_t         state_q, state_d;
    logic [6:0]     s_q, s_d;
    logic [2:0]     seed_cnt_q, seed_cnt_d;
    logic [VW-1:0]  verify_cnt_q, verify_cnt_d;
    logic [WW-1:0]  win_bit_q, win_bit_d;
    logic [EW-1:0]  win_err_q, win_err_d;
    logic           locked_q, locked_d;
    logic           err_q, err_d;
    logic [CNT_WIDTH-1:0] bit_cnt_q, bit_cnt_d;
    logic [CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;

    logic          rx_bit;
    logic          exp_bit;
    logic          mismatch;
    logic [EW-1:0] win_err_base;

    always_comb begin
        rx_bit       = (sig >= SIG_ZERO);
        exp_bit      = s_q[6] ^ s_q[5];
        mismatch     = rx_bit ^ exp_bit;
        win_err_base = win_err_q;

        state_d      = state_q;
        s_d          = s_q;
        seed_cnt_d   = seed_cnt_q;
        verify_cnt_d = verify_cnt_q;
        win_bit_d    = win_bit_q;
        win_err_d    = win_err_q;
        err_d        = 1'b0;
        bit_cnt_d    = bit_cnt_q;
        err_cnt_d    = err_cnt_q;

        if (cke) begin
            case (state_q)
                ST_SEED: begin
                    s_d = {s_q[5:0], rx_bit};
                    if (seed_cnt_q == 3'd6) begin
                        seed_cnt_d = 3'd0;
                        // An all-zero seed would lock onto a dead LFSR; keep seeding instead.
                        if (s_d != 7'd0) begin
                            state_d      = ST_VERIFY;
                            verify_cnt_d = '0;
                        end
                    end else begin
                        seed_cnt_d = seed_cnt_q + 3'd1;
                    end
                end
                ST_VERIFY: begin
                    s_d = {s_q[5:0], exp_bit};
                    if (mismatch) begin
                        err_d      = 1'b1;
                        state_d    = ST_SEED;
                        seed_cnt_d = 3'd0;
                    end else if (verify_cnt_q == VW'(LOCK_COUNT - 1)) begin
                        state_d   = ST_LOCKED;
                        win_bit_d = '0;
                        win_err_d = '0;
                    end else begin
                        verify_cnt_d = verify_cnt_q + 1'b1;
                    end
                end
                ST_LOCKED: begin
                    s_d = {s_q[5:0], exp_bit};
                    if (bit_cnt_q != CNT_MAX) bit_cnt_d = bit_cnt_q + 1'b1;
                    if (mismatch) begin
                        err_d = 1'b1;
                        if (err_cnt_q != CNT_MAX) err_cnt_d = err_cnt_q + 1'b1;
                    end
                    // A zero window counter means freshly locked; treat it as a window start.
                    if (win_bit_q == '0 || win_bit_q == WW'(WINDOW)) begin
                        win_bit_d    = WW'(1);
                        win_err_base = '0;
                    end else begin
                        win_bit_d = win_bit_q + 1'b1;
                    end
                    win_err_d = win_err_base + EW'(mismatch);
                    if (win_err_d == EW'(UNLOCK_ERRS)) begin
                        state_d    = ST_SEED;
                        seed_cnt_d = 3'd0;
                    end
                end
                default: begin
                    state_d    = ST_SEED;
                    seed_cnt_d = 3'd0;
                end
            endcase
        end

        if (clear) begin
            bit_cnt_d = '0;
            err_cnt_d = '0;
        end

        locked_d = (state_d == ST_LOCKED);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_SEED;
            s_q          <= '0;
            seed_cnt_q   <= '0;
            verify_cnt_q <= '0;
            win_bit_q    <= '0;
            win_err_q    <= '0;
            locked_q     <= 1'b0;
            err_q        <= 1'b0;
            bit_cnt_q    <= '0;
            err_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            s_q          <= s_d;
            seed_cnt_q   <= seed_cnt_d;
            verify_cnt_q <= verify_cnt_d;
            win_bit_q    <= win_bit_d;
            win_err_q    <= win_err_d;
            locked_q     <= locked_d;
            err_q        <= err_d;
            bit_cnt_q    <= bit_cnt_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign locked  = locked_q;
    assign err     = err_q;
    assign bit_cnt = bit_cnt_q;
    assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_rx_prbs_checker.sv
// tb/tb_rx_prbs_checker.sv - directed self-checking bench for rx_prbs_checker
module tb_rx_prbs_checker;

    logic               clk = 1'b0;
    logic               rst;
    logic               cke;
    logic signed [15:0] sig;
    logic               clear;
    logic               locked;
    logic               err;
    logic [3:0]         bit_cnt;
    logic [3:0]         err_cnt;

    int checks = 0;
    int errors = 0;

    logic [6:0] g;
    logic       exp_lk;
    logic [3:0] exp_bits;
    logic [3:0] exp_errc;
    int         lk_bits;
    int         err_seen;
    int         lk_seen;

    always #5 clk = ~clk;

    rx_prbs_checker #(
        .SIG_WIDTH  (16),
        .CNT_WIDTH  (4),
        .LOCK_COUNT (32),
        .WINDOW     (64),
        .UNLOCK_ERRS(8)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .cke    (cke),
        .sig    (sig),
        .clear  (clear),
        .locked (locked),
        .err    (err),
        .bit_cnt(bit_cnt),
        .err_cnt(err_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input logic c, input logic b, input logic clr);
        @(negedge clk);
        cke   = c;
        sig   = b ? 16'sd1000 : -16'sd1000;
        clear = clr;
        @(posedge clk);
        #1;
        cke   = 1'b0;
        clear = 1'b0;
        if (err) err_seen++;
        if (locked) lk_seen++;
    endtask

    task automatic send(input logic inv, input logic clr);
        logic b;
        b = g[6] ^ g[5];
        g = {g[5:0], b};
        tick(1'b1, b ^ inv, clr);
        if (exp_lk) begin
            lk_bits++;
            if (exp_bits != 4'hF) exp_bits++;
            if (inv && exp_errc != 4'hF) exp_errc++;
        end
        if (clr) begin
            exp_bits = 4'd0;
            exp_errc = 4'd0;
        end
    endtask

    task automatic idle();
        tick(1'b0, 1'b0, 1'b0);
    endtask

    task automatic lock_up(input string tag);
        for (int i = 0; i < 38; i++) send(1'b0, 1'b0);
        check({tag, "_pre"}, locked, 1'b0);
        send(1'b0, 1'b0);
        check({tag, "_lock"}, locked, 1'b1);
        exp_lk  = 1'b1;
        lk_bits = 0;
    endtask

    task automatic align();
        while (lk_bits % 64 != 0) send(1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst   = 1'b0;
        cke   = 1'b1;
        clear = 1'b1;
        sig   = 16'sd1000;
        @(posedge clk);
        #1;
        rst      = 1'b1;
        cke      = 1'b0;
        clear    = 1'b0;
        exp_lk   = 1'b0;
        exp_bits = 4'd0;
        exp_errc = 4'd0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0; cke = 1'b0; clear = 1'b0; sig = '0;
        g = 7'h7F; exp_lk = 1'b0; exp_bits = '0; exp_errc = '0;
        lk_bits = 0; err_seen = 0; lk_seen = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_locked", locked, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_bit_cnt", bit_cnt, 4'd0);
        check("rst_err_cnt", err_cnt, 4'd0);
        @(negedge clk);
        rst = 1'b1;

        // Clean acquisition
        err_seen = 0;
        lock_up("acq");
        check("acq_no_err", err_seen, 0);
        check("acq_bit_cnt", bit_cnt, 4'd0);
        for (int i = 0; i < 3; i++) send(1'b0, 1'b0);
        check("bit_cnt_inc", bit_cnt, 4'd3);
        idle(); idle();
        check("cke0_bit_cnt", bit_cnt, 4'd3);
        check("cke0_err", err, 1'b0);
        send(1'b0, 1'b1);
        check("clear_bit_cnt", bit_cnt, 4'd0);

        // Single error
        send(1'b1, 1'b0);
        check("single_err_pulse", err, 1'b1);
        check("single_err_cnt", err_cnt, 4'd1);
        check("single_locked", locked, 1'b1);
        send(1'b0, 1'b0);
        check("single_err_drop", err, 1'b0);

        // Eight errors in one window
        align();
        for (int i = 0; i < 8; i++) begin
            send(1'b1, 1'b0);
            if (i == 6) check("loss_7th_locked", locked, 1'b1);
        end
        check("loss_locked", locked, 1'b0);
        check("loss_err", err, 1'b1);
        check("loss_err_cnt", err_cnt, 4'd9);
        check("loss_bit_cnt", bit_cnt, exp_bits);
        exp_lk = 1'b0;
        lock_up("relock");
        check("relock_err_hold", err_cnt, 4'd9);
        check("relock_bit_hold", bit_cnt, 4'hF);

        // Saturation
        send(1'b0, 1'b1);
        check("clear2_err_cnt", err_cnt, 4'd0);
        for (int w = 0; w < 2; w++) begin
            align();
            for (int i = 0; i < 7; i++) begin
                send(1'b1, 1'b0);
                send(1'b0, 1'b0);
            end
            check("win7_locked", locked, 1'b1);
        end
        check("err_cnt_14", err_cnt, 4'd14);
        align();
        for (int i = 0; i < 3; i++) send(1'b1, 1'b0);
        check("err_cnt_sat", err_cnt, 4'hF);
        check("bit_cnt_sat", bit_cnt, 4'hF);
        check("sat_model", err_cnt, exp_errc);
        send(1'b1, 1'b1);
        check("clear_wins_err_cnt", err_cnt, 4'd0);
        check("clear_wins_bit_cnt", bit_cnt, 4'd0);
        check("clear_wins_err", err, 1'b1);

        // Reset while locked overrides cke and clear
        do_reset();
        check("midrst_locked", locked, 1'b0);
        check("midrst_err", err, 1'b0);
        check("midrst_bit_cnt", bit_cnt, 4'd0);
        check("midrst_err_cnt", err_cnt, 4'd0);

        // Strobed every third cycle
        err_seen = 0;
        for (int i = 0; i < 39; i++) begin
            send(1'b0, 1'b0);
            if (i == 37) check("strobe_pre", locked, 1'b0);
            if (i == 38) check("strobe_lock", locked, 1'b1);
            idle(); idle();
        end
        exp_lk = 1'b1;
        send(1'b0, 1'b0);
        check("strobe_bit1", bit_cnt, 4'd1);
        idle(); idle();
        check("strobe_hold", bit_cnt, 4'd1);
        check("strobe_no_err", err_seen, 0);

        // All-zero input never locks
        do_reset();
        err_seen = 0;
        lk_seen  = 0;
        for (int i = 0; i < 200; i++) tick(1'b1, 1'b0, 1'b0);
        check("zero_locked", locked, 1'b0);
        check("zero_lk_seen", lk_seen, 0);
        check("zero_err_seen", err_seen, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
